// File: rtl/rr_stage.sv
// Register-read stage: register file with write-back bypass, main control decode,
// sign extension and load-use hazard detection with bubble insertion.
module rr_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        flush,
    input  logic [31:0] instr,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        mem_memread,
    input  logic [4:0]  mem_rt,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [4:0]  rso,
    output logic [4:0]  rto,
    output logic [4:0]  rdo,
    output logic [5:0]  opcodeo,
    output logic [5:0]  funco,
    output logic [25:0] addresso,
    output logic [15:0] immediateo,
    output logic [31:0] rdo1,
    output logic [31:0] rdo2,
    output logic [31:0] signexto,
    output logic        RegDsto,
    output logic        ALUSrco,
    output logic        MemtoRego,
    output logic        RegWriteo,
    output logic        MemReado,
    output logic        MemWriteo,
    output logic        Jumpo,
    output logic [1:0]  ALUOpo,
    output logic        stall,
    output logic [15:0] stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [31:0] r_rf [32];
    logic [15:0] r_stall_cnt;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic        w_wb_live;
    logic        w_uses_rs;
    logic        w_uses_rt;
    logic        w_hit_ex;
    logic        w_hit_mem;
    logic        w_stall;
    logic        w_live;
    logic        w_regdst, w_alusrc, w_memtoreg, w_regwrite;
    logic        w_memread, w_memwrite, w_jump;
    logic [1:0]  w_aluop;

    assign w_op = instr[31:26];
    assign w_rs = instr[25:21];
    assign w_rt = instr[20:16];

    assign rso        = w_rs;
    assign rto        = w_rt;
    assign rdo        = instr[15:11];
    assign opcodeo    = w_op;
    assign funco      = instr[5:0];
    assign addresso   = instr[25:0];
    assign immediateo = instr[15:0];
    assign signexto   = {{16{instr[15]}}, instr[15:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wb_regwrite && (wb_addr != 5'd0)) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    // Same-cycle write-back wins over the stored value; $0 is never bypassed.
    assign w_wb_live = wb_regwrite && (wb_addr != 5'd0);
    assign rdo1 = (w_rs == 5'd0) ? 32'd0 :
                  (w_wb_live && (wb_addr == w_rs)) ? wb_data : r_rf[w_rs];
    assign rdo2 = (w_rt == 5'd0) ? 32'd0 :
                  (w_wb_live && (wb_addr == w_rt)) ? wb_data : r_rf[w_rt];

    always_comb begin
        w_regdst   = 1'b0;
        w_alusrc   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_jump     = 1'b0;
        w_aluop    = 2'b00;
        case (w_op)
            OP_RTYPE: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_aluop    = 2'b10;
            end
            OP_LW: begin
                w_alusrc   = 1'b1;
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_memread  = 1'b1;
            end
            OP_SW: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            OP_BEQ:  w_aluop = 2'b01;
            OP_ADDI: begin
                w_alusrc   = 1'b1;
                w_regwrite = 1'b1;
            end
            OP_J:    w_jump = 1'b1;
            default: ;
        endcase
    end

    assign w_uses_rs = (w_op != OP_J);
    assign w_uses_rt = (w_op == OP_RTYPE) || (w_op == OP_SW) || (w_op == OP_BEQ);

    assign w_hit_ex  = ex_memread && (ex_rt != 5'd0) &&
                       ((w_uses_rs && (ex_rt == w_rs)) || (w_uses_rt && (ex_rt == w_rt)));
    assign w_hit_mem = mem_memread && (mem_rt != 5'd0) &&
                       ((w_uses_rs && (mem_rt == w_rs)) || (w_uses_rt && (mem_rt == w_rt)));
    assign w_stall   = in_valid && !flush && (w_hit_ex || w_hit_mem);
    assign stall     = w_stall;

    assign w_live    = in_valid && !flush && !w_stall;
    assign RegDsto   = w_live & w_regdst;
    assign ALUSrco   = w_live & w_alusrc;
    assign MemtoRego = w_live & w_memtoreg;
    assign RegWriteo = w_live & w_regwrite;
    assign MemReado  = w_live & w_memread;
    assign MemWriteo = w_live & w_memwrite;
    assign Jumpo     = w_live & w_jump;
    assign ALUOpo    = w_live ? w_aluop : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_rr_stage.sv
// Bench for rr_stage: directed cases plus randomized traffic against a behavioural model.
module tb_rr_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush;
    logic [31:0] instr;
    logic        ex_memread, mem_memread;
    logic [4:0]  ex_rt, mem_rt;
    logic        wb_regwrite;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rso, rto, rdo;
    logic [5:0]  opcodeo, funco;
    logic [25:0] addresso;
    logic [15:0] immediateo;
    logic [31:0] rdo1, rdo2, signexto;
    logic        RegDsto, ALUSrco, MemtoRego, RegWriteo, MemReado, MemWriteo, Jumpo;
    logic [1:0]  ALUOpo;
    logic        stall;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_rf [32];
    int          m_cnt;

    always #5 clk = ~clk;

    rr_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .instr(instr),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_memread(mem_memread), .mem_rt(mem_rt),
        .wb_regwrite(wb_regwrite), .wb_addr(wb_addr), .wb_data(wb_data),
        .rso(rso), .rto(rto), .rdo(rdo), .opcodeo(opcodeo), .funco(funco),
        .addresso(addresso), .immediateo(immediateo), .rdo1(rdo1), .rdo2(rdo2),
        .signexto(signexto), .RegDsto(RegDsto), .ALUSrco(ALUSrco), .MemtoRego(MemtoRego),
        .RegWriteo(RegWriteo), .MemReado(MemReado), .MemWriteo(MemWriteo), .Jumpo(Jumpo),
        .ALUOpo(ALUOpo), .stall(stall), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Control word order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Jump ALUOp[1:0]
    function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 9'b1_0_0_1_0_0_0_10;
            6'h23:   return 9'b0_1_1_1_1_0_0_00;
            6'h2B:   return 9'b0_1_0_0_0_1_0_00;
            6'h04:   return 9'b0_0_0_0_0_0_0_01;
            6'h08:   return 9'b0_1_0_1_0_0_0_00;
            6'h02:   return 9'b0_0_0_0_0_0_1_00;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic ref_stall();
        logic [4:0] srcs [$];
        logic [5:0] op;
        op = instr[31:26];
        if (!in_valid || flush) return 1'b0;
        if (op != 6'h02) srcs.push_back(instr[25:21]);
        if (op == 6'h00 || op == 6'h2B || op == 6'h04) srcs.push_back(instr[20:16]);
        foreach (srcs[i]) begin
            if (srcs[i] == 5'd0) continue;
            if (ex_memread && ex_rt == srcs[i]) return 1'b1;
            if (mem_memread && mem_rt == srcs[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_regwrite && wb_addr == r) return wb_data;
        return m_rf[r];
    endfunction

    task automatic check_all(input string tag);
        logic        s;
        logic [8:0]  c;
        logic [8:0]  got_c;
        s = ref_stall();
        c = (in_valid && !flush && !s) ? ref_ctrl(instr[31:26]) : 9'b0;
        got_c = {RegDsto, ALUSrco, MemtoRego, RegWriteo, MemReado, MemWriteo, Jumpo, ALUOpo};
        chk({tag, ".rs"},    32'(rso),        32'(instr[25:21]));
        chk({tag, ".rt"},    32'(rto),        32'(instr[20:16]));
        chk({tag, ".rd"},    32'(rdo),        32'(instr[15:11]));
        chk({tag, ".op"},    32'(opcodeo),    32'(instr[31:26]));
        chk({tag, ".fn"},    32'(funco),      32'(instr[5:0]));
        chk({tag, ".addr"},  32'(addresso),   32'(instr[25:0]));
        chk({tag, ".imm"},   32'(immediateo), 32'(instr[15:0]));
        chk({tag, ".sext"},  signexto,        32'($signed(instr[15:0])));
        chk({tag, ".rdo1"},  rdo1,            ref_read(instr[25:21]));
        chk({tag, ".rdo2"},  rdo2,            ref_read(instr[20:16]));
        chk({tag, ".ctrl"},  32'(got_c),      32'(c));
        chk({tag, ".stall"}, 32'(stall),      32'(s));
        chk({tag, ".cnt"},   32'(stall_cnt),  32'(m_cnt));
    endtask

    // Model state advances on every posedge from the inputs that were stable before it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_cnt = 0;
        end else begin
            if (ref_stall() && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (wb_regwrite && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction

    initial begin
        logic [5:0] ops [7];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h0D};

        rst = 1'b0; in_valid = 1'b1; flush = 1'b0; instr = 32'd0;
        ex_memread = 1'b0; ex_rt = 5'd0; mem_memread = 1'b0; mem_rt = 5'd0;
        wb_regwrite = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_cnt = 0;
        repeat (3) step();
        check_all("rst_hold");

        wb_regwrite = 1'b0;
        instr = rtype(5, 0, 3);
        rst = 1'b1;
        #1;
        chk("rst_rdo1", rdo1, 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        step();

        instr = rtype(8, 0, 3);
        wb_regwrite = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234;
        #1;
        chk("byp_rdo1", rdo1, 32'h1234);
        check_all("byp");
        step();
        wb_regwrite = 1'b0;
        #1;
        chk("rf_rdo1", rdo1, 32'h1234);
        step();
        instr = rtype(8, 0, 3);
        wb_regwrite = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        #1;
        chk("r0_byp", rdo2, 32'd0);
        step();
        wb_regwrite = 1'b0;
        #1;
        chk("r0_rf", rdo2, 32'd0);

        instr = 32'h8D09FFFC;
        #1;
        chk("lw_ctrl", 32'({RegDsto, ALUSrco, MemtoRego, RegWriteo, MemReado, MemWriteo, Jumpo, ALUOpo}),
            32'(9'b0_1_1_1_1_0_0_00));
        chk("lw_sext", signexto, 32'hFFFFFFFC);
        instr = 32'h08000010;
        #1;
        chk("j_jump", 32'(Jumpo), 32'd1);
        chk("j_addr", 32'(addresso), 32'h10);

        instr = rtype(9, 1, 10);
        ex_memread = 1'b1; ex_rt = 5'd9;
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_ctrl", 32'({RegDsto, ALUSrco, MemtoRego, RegWriteo, MemReado, MemWriteo, Jumpo, ALUOpo}), 32'd0);
        ex_rt = 5'd0;
        #1;
        chk("lu_rt0", 32'(stall), 32'd0);
        ex_rt = 5'd9;
        instr = {6'h2B, 5'd2, 5'd9, 16'h0008};
        #1;
        chk("lu_sw", 32'(stall), 32'd1);
        step();
        check_all("lu_cnt");

        instr = rtype(9, 1, 10);
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 32'd0);
        check_all("fl");
        step();
        chk("fl_cnt", 32'(stall_cnt), 32'(m_cnt));
        flush = 1'b0;
        ex_memread = 1'b0;

        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 6)];
            instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            in_valid    = ($urandom_range(0, 7) != 0);
            flush       = ($urandom_range(0, 7) == 0);
            ex_memread  = $urandom_range(0, 1) == 1;
            ex_rt       = 5'($urandom_range(0, 7));
            mem_memread = $urandom_range(0, 1) == 1;
            mem_rt      = 5'($urandom_range(0, 7));
            wb_regwrite = $urandom_range(0, 1) == 1;
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            #1;
            check_all("rand");
            step();
        end

        in_valid = 1'b1; flush = 1'b0; wb_regwrite = 1'b0;
        mem_memread = 1'b0;
        instr = rtype(9, 1, 10);
        ex_memread = 1'b1; ex_rt = 5'd9;
        repeat (100) step();
        #1;
        check_all("cnt100");
        repeat (70000) @(posedge clk);
        @(negedge clk);
        #1;
        chk("cnt_sat", 32'(stall_cnt), 32'hFFFF);
        check_all("cnt_sat_all");
        step();
        chk("cnt_hold", 32'(stall_cnt), 32'hFFFF);

        rst = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
        chk("mid_rst_rf", rdo1, 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd1);
        step();
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
